// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory.
// Optional misalignment trap: define DATA_MEM_ARB_ALIGN_CHECK_EN.
module data_mem_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [2:0]  memsrc0,
  output logic        ack0,
  output logic        done0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [2:0]  memsrc1,
  output logic        ack1,
  output logic        done1,
  output logic [31:0] rdata1,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  output logic [2:0]  mem_MemSrc,
  input  logic [31:0] mem_RD,
  output logic        err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nx;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  cmd_memsrc;
  logic        cmd_owner;
  logic        cmd_bad;
  logic        last_winner;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_memsrc;
  logic        bad_in;

  always_comb begin
    state_nx = state;
    ack0     = 1'b0;
    ack1     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          if (req0 && req1) begin
            // Port 0 wins when last_winner was port 1 or priority is fixed.
            if (FIXED_PRIO != 0 || last_winner)
              ack0 = 1'b1;
            else
              ack1 = 1'b1;
          end else begin
            ack0 = req0;
            ack1 = req1;
          end
        end
        if (ack0 || ack1)
          state_nx = ACCESS;
      end
      ACCESS: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sel_we     = ack1 ? we1     : we0;
  assign sel_addr   = ack1 ? addr1   : addr0;
  assign sel_wdata  = ack1 ? wdata1  : wdata0;
  assign sel_memsrc = ack1 ? memsrc1 : memsrc0;

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
  assign bad_in = sel_memsrc[1] ? |sel_addr[1:0]
                                : sel_memsrc[0] & sel_addr[0];
`else
  assign bad_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_memsrc  <= '0;
      cmd_owner   <= 1'b0;
      cmd_bad     <= 1'b0;
      last_winner <= 1'b1;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_nx;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      if (state == ACCESS) begin
        if (cmd_owner) begin
          done1  <= 1'b1;
          rdata1 <= cmd_bad ? 32'h0 : mem_RD;
        end else begin
          done0  <= 1'b1;
          rdata0 <= cmd_bad ? 32'h0 : mem_RD;
        end
        err        <= cmd_bad;
        cmd_we     <= 1'b0;
        cmd_addr   <= '0;
        cmd_wdata  <= '0;
        cmd_memsrc <= '0;
        cmd_owner  <= 1'b0;
        cmd_bad    <= 1'b0;
      end else if (ack0 || ack1) begin
        cmd_we      <= sel_we;
        cmd_addr    <= sel_addr;
        cmd_wdata   <= sel_wdata;
        cmd_memsrc  <= sel_memsrc;
        cmd_owner   <= ack1;
        cmd_bad     <= bad_in;
        last_winner <= ack1;
      end
    end
  end

  assign mem_A      = cmd_addr;
  assign mem_WD     = cmd_wdata;
  assign mem_MemSrc = cmd_memsrc;
  assign mem_WE     = (state == ACCESS) & cmd_we & ~cmd_bad & ~rst;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-lane memory model.
// A second instance exercises fixed-priority arbitration.
module tb_data_mem_arbiter;

`ifdef DATA_MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk, rst;
  logic req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [2:0]  memsrc0, memsrc1;
  logic ack0, done0, ack1, done1, mem_WE, err;
  logic [31:0] rdata0, rdata1, mem_A, mem_WD, mem_RD;
  logic [2:0]  mem_MemSrc;

  logic f_req0, f_we0, f_req1, f_we1;
  logic [31:0] f_addr0, f_wdata0, f_addr1, f_wdata1;
  logic [2:0]  f_memsrc0, f_memsrc1;
  logic f_ack0, f_done0, f_ack1, f_done1, f_mem_WE, f_err;
  logic [31:0] f_rdata0, f_rdata1, f_mem_A, f_mem_WD, f_mem_RD;
  logic [2:0]  f_mem_MemSrc;

  int checks = 0;
  int errors = 0;

  bit [7:0] mem [0:1023];
  logic [7:0] b0, b1, b2, b3;
  logic [9:0] ma;

  data_mem_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .memsrc0(memsrc0), .ack0(ack0), .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .memsrc1(memsrc1), .ack1(ack1), .done1(done1), .rdata1(rdata1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_MemSrc(mem_MemSrc), .mem_RD(mem_RD), .err(err)
  );

  data_mem_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0),
    .memsrc0(f_memsrc0), .ack0(f_ack0), .done0(f_done0),
    .rdata0(f_rdata0),
    .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1),
    .memsrc1(f_memsrc1), .ack1(f_ack1), .done1(f_done1),
    .rdata1(f_rdata1),
    .mem_A(f_mem_A), .mem_WD(f_mem_WD), .mem_WE(f_mem_WE),
    .mem_MemSrc(f_mem_MemSrc), .mem_RD(f_mem_RD), .err(f_err)
  );

  assign f_mem_RD = f_mem_A ^ 32'h5A5A0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed little-endian memory, 1 KiB window.
  always_comb begin
    ma = mem_A[9:0];
    b0 = mem[ma];
    b1 = mem[ma + 10'd1];
    b2 = mem[ma + 10'd2];
    b3 = mem[ma + 10'd3];
    mem_RD = {b3, b2, b1, b0};
    if (mem_MemSrc[1:0] == 2'b00)
      mem_RD = mem_MemSrc[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
    else if (mem_MemSrc[1:0] == 2'b01)
      mem_RD = mem_MemSrc[2] ? {16'h0, b1, b0}
                             : {{16{b1[7]}}, b1, b0};
  end

  always @(posedge clk) begin
    if (mem_WE) begin
      mem[mem_A[9:0]] <= mem_WD[7:0];
      if (mem_MemSrc[1] || mem_MemSrc[0])
        mem[mem_A[9:0] + 10'd1] <= mem_WD[15:8];
      if (mem_MemSrc[1]) begin
        mem[mem_A[9:0] + 10'd2] <= mem_WD[23:16];
        mem[mem_A[9:0] + 10'd3] <= mem_WD[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on a single port; returns in the done cycle.
  task automatic run(input bit port, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] ms);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; memsrc1 = ms;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; memsrc0 = ms;
    end
    #1;
    check(port ? "run_ack1" : "run_ack0",
          port ? {31'h0, ack1} : {31'h0, ack0}, 32'h1);
    tick;
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; memsrc0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; memsrc1 = 0;
    f_req0 = 0; f_we0 = 0; f_addr0 = 0; f_wdata0 = 0; f_memsrc0 = 0;
    f_req1 = 0; f_we1 = 0; f_addr1 = 0; f_wdata1 = 0; f_memsrc1 = 0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("rst_ack", {30'h0, ack0, ack1}, 32'h0);
    check("rst_done", {30'h0, done0, done1}, 32'h0);
    check("rst_we_err", {30'h0, mem_WE, err}, 32'h0);
    check("rst_mem_a", mem_A, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_f_outs", {f_mem_WE, f_err, f_mem_MemSrc}, 32'h0);
    check("rst_f_wd", f_mem_WD, 32'h0);

    // Word store then load back on port 0.
    req0 = 1; we0 = 1; addr0 = 32'h100; wdata0 = 32'hDEADBEEF;
    memsrc0 = 3'b010;
    #1;
    check("st_ack", {30'h0, ack0, ack1}, 32'h2);
    tick;
    req0 = 0;
    #1;
    check("st_we", {31'h0, mem_WE}, 32'h1);
    check("st_addr", mem_A, 32'h100);
    check("st_wd", mem_WD, 32'hDEADBEEF);
    check("st_no_ack", {30'h0, ack0, ack1}, 32'h0);
    tick;
    check("st_done", {30'h0, done0, done1}, 32'h2);
    req0 = 1; we0 = 0;
    #1;
    check("ld_ack_with_done", {31'h0, ack0}, 32'h1);
    tick;
    req0 = 0;
    #1;
    check("ld_we", {31'h0, mem_WE}, 32'h0);
    tick;
    check("ld_done", {31'h0, done0}, 32'h1);
    check("ld_rdata", rdata0, 32'hDEADBEEF);
    tick;
    check("ld_pulse", {31'h0, done0}, 32'h0);
    check("ld_hold", rdata0, 32'hDEADBEEF);

    // Byte 0x80 via port 1, then signed/unsigned byte loads.
    run(1'b1, 1'b1, 32'h10000, 32'h00000080, 3'b000);
    check("sb_done1", {30'h0, done0, done1}, 32'h1);
    run(1'b0, 1'b0, 32'h10000, 32'h0, 3'b000);
    check("lb_signed", rdata0, 32'hFFFFFF80);
    run(1'b0, 1'b0, 32'h10000, 32'h0, 3'b100);
    check("lbu", rdata0, 32'h00000080);
    check("lbu_r1_kept", rdata1, 32'h0000DEAD ^ 32'h0000DEAD);

    // Misaligned word store on port 1.
    req1 = 1; we1 = 1; addr1 = 32'h102; wdata1 = 32'hCAFEF00D;
    memsrc1 = 3'b010;
    #1;
    check("mis_ack1", {30'h0, ack0, ack1}, 32'h1);
    tick;
    req1 = 0;
    #1;
    check("mis_we", {31'h0, mem_WE}, ALIGN ? 32'h0 : 32'h1);
    tick;
    check("mis_done1", {31'h0, done1}, 32'h1);
    check("mis_err", {31'h0, err}, ALIGN ? 32'h1 : 32'h0);
    check("mis_rdata1", rdata1, ALIGN ? 32'h0 : 32'h0000DEAD);
    run(1'b0, 1'b0, 32'h100, 32'h0, 3'b010);
    check("mis_after", rdata0, ALIGN ? 32'hDEADBEEF : 32'hF00DBEEF);
    check("mis_after_err", {31'h0, err}, 32'h0);

    // Reset during ACCESS aborts the store.
    run(1'b0, 1'b1, 32'h200, 32'h11223344, 3'b010);
    req0 = 1; we0 = 1; addr0 = 32'h200; wdata0 = 32'h55;
    memsrc0 = 3'b000;
    #1;
    tick;
    req0 = 0;
    rst = 1;
    #1;
    check("abort_we", {31'h0, mem_WE}, 32'h0);
    tick;
    rst = 0;
    #1;
    check("abort_done", {30'h0, done0, done1}, 32'h0);
    check("abort_a", mem_A, 32'h0);
    check("abort_wd", mem_WD, 32'h0);
    check("abort_ms", {29'h0, mem_MemSrc}, 32'h0);
    check("abort_rdata0", rdata0, 32'h0);

    // Round-robin with both loads held.
    req0 = 1; we0 = 0; addr0 = 32'h200; memsrc0 = 3'b010;
    req1 = 1; we1 = 0; addr1 = 32'h10000; memsrc1 = 3'b000;
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rr_ack_%0d", g), {30'h0, ack0, ack1},
            (g % 2 == 0) ? 32'h2 : 32'h1);
      tick;
      check($sformatf("rr_busy_%0d", g), {30'h0, ack0, ack1}, 32'h0);
      tick;
      check($sformatf("rr_done_%0d", g), {30'h0, done0, done1},
            (g % 2 == 0) ? 32'h2 : 32'h1);
    end
    req0 = 0;
    req1 = 0;
    check("rr_rdata0", rdata0, 32'h11223344);
    check("rr_rdata1", rdata1, 32'hFFFFFF80);
    tick;

    // Fixed priority: port 1 waits until port 0 drops.
    f_req0 = 1; f_addr0 = 32'h40; f_memsrc0 = 3'b010;
    f_req1 = 1; f_addr1 = 32'h80; f_memsrc1 = 3'b010;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("fp_ack_%0d", g), {30'h0, f_ack0, f_ack1}, 32'h2);
      tick;
      check($sformatf("fp_busy_%0d", g), {30'h0, f_ack0, f_ack1}, 32'h0);
      if (g == 2) f_req0 = 0;
      tick;
    end
    #1;
    check("fp_ack1", {30'h0, f_ack0, f_ack1}, 32'h1);
    check("fp_rdata0", f_rdata0, 32'h5A5A0040);
    tick;
    f_req1 = 0;
    tick;
    check("fp_done1", {30'h0, f_done0, f_done1}, 32'h1);
    check("fp_rdata1", f_rdata1, 32'h5A5A0080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port byte-addressed data memory.
- Port 0 is the CPU load/store stage; port 1 is a secondary master (debug/DMA loader).
- Accepts one request at a time, drives the memory for one access cycle, registers the load result and pulses completion to the winning requester.
- Sits between the requesters and the data memory's A/WD/WE/MemSrc/RD pins.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins contention

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  port 0 request; held stable with its command until ack0
we0  input  1  port 0 store (1) / load (0)
addr0  input  32  port 0 byte address
wdata0  input  32  port 0 store data (low bytes used for SB/SH)
memsrc0  input  3  port 0 size/sign: [1:0] 00 byte, 01 half, 1x word; [2] 1 = unsigned load
ack0  output  1  port 0 request accepted this cycle (combinational)
done0  output  1  port 0 access complete; one-cycle pulse
rdata0  output  32  port 0 load data, valid while done0=1, held until next port-0 done
req1, we1, addr1, wdata1, memsrc1, ack1, done1, rdata1  same as port 0, for port 1
mem_A  output  32  memory address
mem_WD  output  32  memory write data
mem_WE  output  1  memory write enable
mem_MemSrc  output  3  memory size/sign control
mem_RD  input  32  memory combinational read data
err  output  1  misaligned-access flag (see Optional Feature); 0 when feature is compiled out

Behaviour:
- Reset: state IDLE. ack*/done*/mem_WE/err = 0. rdata0/rdata1/mem_A/mem_WD/mem_MemSrc = 0. last_winner = 1, so port 0 wins the first contention.
- FSM has two states, IDLE and ACCESS.
- IDLE, no req: stay IDLE; all memory outputs driven from the zeroed command register with mem_WE = 0.
- IDLE, one req: ackN = 1 in the same cycle. Command {we, addr, wdata, memsrc, owner} is latched at the edge; next state ACCESS.
- IDLE, both req with FIXED_PRIO = 0: winner is the port != last_winner; last_winner updates to the winner at the edge. The loser's ack stays 0 and its request remains pending.
- IDLE, both req with FIXED_PRIO = 1: port 0 always wins.
- ACCESS: mem_A, mem_WD and mem_MemSrc come from the command register; mem_WE = cmd_we & ~rst.
  - At the edge, a store commits in memory and mem_RD is captured into rdata[owner]; rdata of the other port is unchanged.
  - done[owner] = 1 in the following cycle; state returns to IDLE.
- No ack is issued while in ACCESS, so one access completes every 2 cycles.
- Latency: ack at cycle t, memory access at t+1, doneN/rdataN valid at t+2.
- A new ack may coincide with a done pulse at t+2.
- Stores also pulse done; rdata for a store is don't-care but deterministic (the captured mem_RD).
- Deasserting req before ack is legal (request withdrawn); deasserting after ack has no effect.
- Reset in ACCESS aborts the access: mem_WE is forced 0 in the reset cycle, so no write occurs and no done is issued.
- ack0 and ack1 are never both 1; done0 and done1 are never both 1.

Optional Feature:
- Macro: DATA_MEM_ARB_ALIGN_CHECK_EN.
- Enabled, misaligned access = halfword with addr[0] = 1, or word with addr[1:0] != 0:
  - the access is still acked and sequenced;
  - mem_WE is forced 0 in ACCESS;
  - rdata[owner] captures 0;
  - err = 1 for the cycle that done[owner] = 1.
- Disabled: err is tied 0; misaligned accesses pass through unchanged, with the memory handling byte lanes.

Test Plan:
- Reset, then port 0 alone: store word addr 0x100 data 0xDEADBEEF memsrc 010 -> ack0 cycle 1, mem_WE = 1 cycle 2, done0 cycle 3. A following load of 0x100 returns rdata0 = 0xDEADBEEF.
- Both req same cycle, FIXED_PRIO = 0, both loads, held asserted: grants go 0, 1, 0, 1 on cycles 1, 3, 5, 7. Port 1 is never starved and ack0/ack1 are never both 1.
- FIXED_PRIO = 1, both req held: port 0 acked every 2 cycles; port 1 is never acked until req0 drops, then acked the next IDLE cycle.
- Signed byte load: memory byte 0x80 at 0x10000 with memsrc 000 -> rdata0 = 0xFFFFFF80. The same access with memsrc 100 -> 0x00000080.
- rst asserted during ACCESS of store 0x55 to 0x200 -> no done pulse; a later load of 0x200 returns the old value; all outputs are 0 the cycle after reset.
- With DATA_MEM_ARB_ALIGN_CHECK_EN: port 1 word store to 0x102 -> mem_WE stays 0, done1 = 1 with err = 1 and rdata1 = 0. Without the macro -> the store commits and err = 0.
